// File: rtl/mips_pkg.sv
// Shared widths, well-known register indices and index type
// for the ID-stage register file and its scoreboard.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: in-flight producer tracking, pending
// lookups for both source ports and a registered busy count.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_pend,
  output logic              rt_pend,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     cnt_d;
  logic                byp_hit_rs;
  logic                byp_hit_rt;

  // Next busy vector: clear first so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && clr_idx != '0)
      busy_d[clr_idx] = 1'b0;
    if (set_en && set_idx != '0)
      busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  // Busy bits and their count move together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      pend_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      pend_cnt <= cnt_d;
    end
  end

  // A register being written back this cycle is not pending
  // when the write is forwarded to the read ports.
  always_comb begin
    byp_hit_rs = (BYPASS != 0) && clr_en && (clr_idx == rs_addr);
    byp_hit_rt = (BYPASS != 0) && clr_en && (clr_idx == rt_addr);
    rs_pend    = busy_q[rs_addr] && !byp_hit_rs;
    rt_pend    = busy_q[rt_addr] && !byp_hit_rt;
  end

endmodule

// File: rtl/id_regfile_sb.sv
// ID-stage register file: storage, bypassed read ports and
// the load-use stall built from the scoreboard lookups.
module id_regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              iss_valid,
  input  logic              iss_wr,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              rs_pend;
  logic              rt_pend;
  logic              set_en;
  logic              wr_en;

  assign wr_en  = wb_we && (wb_waddr != '0);
  assign set_en = iss_valid && iss_wr && !stall;

  // Architectural state; r0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  // Read port A: r0 reads zero, WB data forwarded if enabled.
  always_comb begin
    rs_data = '0;
    if (rs_addr != '0) begin
      if ((BYPASS != 0) && wb_we && wb_waddr == rs_addr)
        rs_data = wb_wdata;
      else
        rs_data = regs[rs_addr];
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rt_data = '0;
    if (rt_addr != '0) begin
      if ((BYPASS != 0) && wb_we && wb_waddr == rt_addr)
        rt_data = wb_wdata;
      else
        rt_data = regs[rt_addr];
    end
  end

  // Hold ID when a source the instruction uses is pending.
  always_comb begin
    stall = (rs_used && rs_pend) || (rt_used && rt_pend);
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_idx  (iss_rd),
    .clr_en   (wb_we),
    .clr_idx  (wb_waddr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_pend  (rs_pend),
    .rt_pend  (rt_pend),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: array/bitmask model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_id_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        rs_used = 1'b0;
  logic        rt_used = 1'b0;
  logic        iss_valid = 1'b0;
  logic        iss_wr = 1'b0;
  logic [4:0]  iss_rd = '0;

  logic [31:0] rs_data, rt_data, rs_data_b, rt_data_b;
  logic        stall, stall_b;
  logic [5:0]  pend_cnt, pend_cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_used(rs_used), .rt_used(rt_used),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
    .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .pend_cnt(pend_cnt)
  );

  id_regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_used(rs_used), .rt_used(rt_used),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
    .rs_data(rs_data_b), .rt_data(rt_data_b),
    .stall(stall_b), .pend_cnt(pend_cnt_b)
  );

  // Model: register contents and busy mask (bypassing copy).
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  function automatic logic [31:0] m_read(input logic [4:0] a,
                                         input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wb_we && wb_waddr == a) return wb_wdata;
    return m_regs[a];
  endfunction

  function automatic bit m_pend(input logic [4:0] a);
    return m_busy[a] && !(wb_we && wb_waddr == a);
  endfunction

  function automatic bit m_stall();
    return (rs_used && m_pend(rs_addr)) ||
           (rt_used && m_pend(rt_addr));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_busy <= '0;
    end else begin
      if (wb_we && wb_waddr != 0) begin
        m_regs[wb_waddr] <= wb_wdata;
        m_busy[wb_waddr] <= 1'b0;
      end
      if (iss_valid && iss_wr && iss_rd != 0 && !m_stall())
        m_busy[iss_rd] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("cyc_rs", rs_data, m_read(rs_addr, 1'b1));
    check("cyc_rt", rt_data, m_read(rt_addr, 1'b1));
    check("cyc_stall", {31'b0, stall}, {31'b0, m_stall()});
    check("cyc_cnt", {26'b0, pend_cnt},
          $countones(m_busy));
    check("cyc_rs_nb", rs_data_b, m_read(rs_addr, 1'b0));
    check("cyc_rt_nb", rt_data_b, m_read(rt_addr, 1'b0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
    iss_valid = 0; iss_wr = 0; iss_rd = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1; iss_wr = 1; iss_rd = rd;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rs", rs_data, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_cnt", {26'b0, pend_cnt}, 32'h0);
    step();
    rst = 1;

    // write r7, read back next cycle
    wb(7, 32'h1234_5678);
    step(); idle(); rs_addr = 7;
    @(negedge clk);
    check("wr_r7", rs_data, 32'h1234_5678);

    // r0 write dropped
    step(); wb(0, 32'hFFFF_FFFF);
    step(); idle(); rs_addr = 0; rt_addr = 0;
    @(negedge clk);
    check("r0_zero", rs_data, 32'h0);

    // bypass vs no bypass
    step(); wb(9, 32'h1111_2222);
    step(); wb(9, 32'hA5A5_0001); rt_addr = 9;
    @(negedge clk);
    check("byp_on", rt_data, 32'hA5A5_0001);
    check("byp_off", rt_data_b, 32'h1111_2222);
    step(); idle(); rt_addr = 9;
    @(negedge clk);
    check("byp_after", rt_data_b, 32'hA5A5_0001);

    // load-use stall on r4
    step(); idle(); issue(4);
    step(); idle(); rs_addr = 4; rs_used = 1;
    @(negedge clk);
    check("lu_stall", {31'b0, stall}, 32'h1);
    check("lu_cnt", {26'b0, pend_cnt}, 32'h1);
    step(); wb(4, 32'h0000_0044);
    @(negedge clk);
    check("lu_byp_nostall", {31'b0, stall}, 32'h0);
    check("lu_byp_data", rs_data, 32'h0000_0044);
    step(); idle(); rs_addr = 4; rs_used = 1;
    @(negedge clk);
    check("lu_cnt_clr", {26'b0, pend_cnt}, 32'h0);
    check("lu_stall_clr", {31'b0, stall}, 32'h0);

    // set/clear collision on r3
    step(); idle(); issue(3);
    step(); idle(); issue(3); wb(3, 32'h0000_0033);
    @(negedge clk);
    check("col_cnt_before", {26'b0, pend_cnt}, 32'h1);
    step(); idle(); rs_addr = 3; rs_used = 1;
    @(negedge clk);
    check("col_cnt_after", {26'b0, pend_cnt}, 32'h1);
    check("col_stall", {31'b0, stall}, 32'h1);
    // issue while stalled must not mark r6
    step(); issue(6);
    step(); idle();
    @(negedge clk);
    check("stall_noset", {26'b0, pend_cnt}, 32'h1);
    step(); wb(3, 32'h0000_0003);
    step(); idle();
    @(negedge clk);
    check("col_clear", {26'b0, pend_cnt}, 32'h0);

    // link write to r31
    step(); wb(31, 32'h0040_0010);
    step(); idle(); rs_addr = 31;
    @(negedge clk);
    check("link_r31", rs_data, 32'h0040_0010);

    // directed table mixing writes, issues and reads
    for (int i = 0; i < 16; i++) begin
      step(); idle();
      wb_we = i[0];
      wb_waddr = 5'((i * 3) % 32);
      wb_wdata = 32'h0101_0101 * i;
      iss_valid = 1; iss_wr = i[2] | i[0];
      iss_rd = 5'((i * 5) % 32);
      rs_addr = 5'((i * 7) % 32);
      rt_addr = 5'((i * 3) % 32);
      rs_used = i[1]; rt_used = 1;
    end
    step(); idle();
    for (int i = 1; i < 32; i++) begin
      step(); wb(5'(i), 32'hC000_0000 + i);
      rs_addr = 5'(i); rt_addr = 5'(32 - i);
    end
    step(); idle();

    // mid-cycle asynchronous reset
    step(); wb(5, 32'hDEAD_BEEF); issue(8);
    step(); idle(); rs_addr = 5;
    @(negedge clk);
    check("pre_rst_r5", rs_data, 32'hDEAD_BEEF);
    check("pre_rst_cnt", {26'b0, pend_cnt}, 32'h1);
    step(); #1;
    rst = 0;
    #1;
    check("rst_async_r5", rs_data, 32'h0);
    check("rst_async_cnt", {26'b0, pend_cnt}, 32'h0);
    wb(5, 32'h5555_5555);
    step(); idle(); rs_addr = 5;
    @(negedge clk);
    check("rst_no_write", rs_data, 32'h0);
    step(); rst = 1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
